// File: rtl/deth_layer_sched_if.sv
// Request bundle between the box-filter scale layers and the det-of-Hessian scheduler.
// Operands are packed per layer: layer i occupies [i*DW +: DW].
interface deth_layer_sched_if #(
  parameter int N  = 4,
  parameter int DW = 21
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dxx;
  logic [N*DW-1:0] req_dyy;
  logic [N*DW-1:0] req_dxy;

  modport master (output req_valid, req_dxx, req_dyy, req_dxy, input req_ready);
  modport slave  (input req_valid, req_dxx, req_dyy, req_dxy, output req_ready);
endinterface

// File: rtl/deth_layer_sched.sv
// Round-robin scheduler sharing one det-of-Hessian pipeline among N scale layers,
// with per-layer constants, result tagging and per-layer frame counting.
module deth_layer_sched #(
  parameter int N         = 4,
  parameter int DW        = 21,
  parameter int CW        = 18,
  parameter int OW        = 32,
  parameter int LAT       = 4,
  parameter int CONST_DLY = 2,
  parameter int FRAME_PIX = 1024,
  parameter logic [CW-1:0] DEF_A = CW'(1165),
  parameter logic [CW-1:0] DEF_B = CW'(2595),
  localparam int LW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         layer_en,
  deth_layer_sched_if.slave    req_if,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_layer,
  input  logic                 cfg_sel,
  input  logic [CW-1:0]        cfg_wdata,
  output logic signed [DW-1:0] pipe_dxx,
  output logic signed [DW-1:0] pipe_dyy,
  output logic signed [DW-1:0] pipe_dxy,
  output logic                 pipe_valid,
  output logic [CW-1:0]        pipe_const_xx,
  output logic [CW-1:0]        pipe_const_xy,
  input  logic signed [OW-1:0] pipe_det,
  input  logic                 pipe_det_valid,
  output logic signed [OW-1:0] det_o,
  output logic                 det_o_valid,
  output logic [LW-1:0]        det_o_layer,
  output logic [N-1:0]         frame_done,
  output logic                 err_tag
);
  localparam int             FCW      = $clog2(FRAME_PIX);
  localparam logic [LW-1:0]  LAST_L   = LW'(N - 1);
  localparam logic [FCW-1:0] LAST_CNT = FCW'(FRAME_PIX - 1);

  // Arbitration: first enabled requester at or after the pointer
  logic [LW-1:0] ptr_q, ptr_d, gnt_idx, cand;
  logic          gnt_any, xfer;
  logic [N-1:0]  gnt;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = LW'((int'(ptr_q) + k) % N);
      if (!gnt_any && req_if.req_valid[cand] && layer_en[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any && !rst) gnt[gnt_idx] = 1'b1;
  end

  assign xfer             = gnt_any & ~rst;
  assign req_if.req_ready = gnt;
  assign ptr_d            = xfer ? ((gnt_idx == LAST_L) ? '0 : gnt_idx + 1'b1) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Operand stage: winner's operands registered toward the pipeline
  logic signed [DW-1:0] dxx_q, dyy_q, dxy_q;
  logic                 vld_q;
  logic [LW-1:0]        lay_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      lay_q <= '0;
      dxx_q <= '0;
      dyy_q <= '0;
      dxy_q <= '0;
    end else begin
      vld_q <= xfer;
      if (xfer) begin
        lay_q <= gnt_idx;
        dxx_q <= $signed(req_if.req_dxx[int'(gnt_idx)*DW +: DW]);
        dyy_q <= $signed(req_if.req_dyy[int'(gnt_idx)*DW +: DW]);
        dxy_q <= $signed(req_if.req_dxy[int'(gnt_idx)*DW +: DW]);
      end
    end
  end

  // Constant table; a same-cycle write does not affect the concurrent grant
  logic [CW-1:0] kxx_q [N];
  logic [CW-1:0] kxy_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        kxx_q[i] <= DEF_A;
        kxy_q[i] <= DEF_B;
      end
    end else if (cfg_we && int'(cfg_layer) < N) begin
      if (cfg_sel) kxy_q[cfg_layer] <= cfg_wdata;
      else         kxx_q[cfg_layer] <= cfg_wdata;
    end
  end

  // Constant delay chain aligning the grant-time constants to the stage-2 multipliers
  logic          cv_q  [CONST_DLY];
  logic [CW-1:0] cxx_q [CONST_DLY];
  logic [CW-1:0] cxy_q [CONST_DLY];
  logic [CW-1:0] kxx_o_q, kxy_o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CONST_DLY; k++) cv_q[k] <= 1'b0;
      kxx_o_q <= DEF_A;
      kxy_o_q <= DEF_B;
    end else begin
      cv_q[0] <= xfer;
      for (int k = 1; k < CONST_DLY; k++) cv_q[k] <= cv_q[k-1];
      if (cv_q[CONST_DLY-1]) begin
        kxx_o_q <= cxx_q[CONST_DLY-1];
        kxy_o_q <= cxy_q[CONST_DLY-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      cxx_q[0] <= kxx_q[gnt_idx];
      cxy_q[0] <= kxy_q[gnt_idx];
    end
    for (int k = 1; k < CONST_DLY; k++) begin
      if (cv_q[k-1]) begin
        cxx_q[k] <= cxx_q[k-1];
        cxy_q[k] <= cxy_q[k-1];
      end
    end
  end

  // Tag chain: mirrors the pipeline's valid so results can be attributed to a layer
  logic          tv_q [LAT];
  logic [LW-1:0] tl_q [LAT];
  logic          tag_v;
  logic [LW-1:0] tag_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        tv_q[k] <= 1'b0;
        tl_q[k] <= '0;
      end
    end else begin
      tv_q[0] <= vld_q;
      tl_q[0] <= lay_q;
      for (int k = 1; k < LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        tl_q[k] <= tl_q[k-1];
      end
    end
  end

  assign tag_v = tv_q[LAT-1];
  assign tag_l = tl_q[LAT-1];

  // Result stage: tagging, frame counting and tag/valid consistency
  logic signed [OW-1:0] det_q;
  logic                 det_vld_q, err_q;
  logic [LW-1:0]        det_lay_q;
  logic [N-1:0]         done_q;
  logic [FCW-1:0]       cnt_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q     <= '0;
      det_vld_q <= 1'b0;
      det_lay_q <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      det_vld_q <= pipe_det_valid & tag_v;
      done_q    <= '0;
      if (pipe_det_valid && tag_v) begin
        det_q     <= pipe_det;
        det_lay_q <= tag_l;
        if (cnt_q[tag_l] == LAST_CNT) begin
          cnt_q[tag_l]  <= '0;
          done_q[tag_l] <= 1'b1;
        end else begin
          cnt_q[tag_l] <= cnt_q[tag_l] + 1'b1;
        end
      end
      if (pipe_det_valid != tag_v) err_q <= 1'b1;
    end
  end

  assign pipe_dxx      = dxx_q;
  assign pipe_dyy      = dyy_q;
  assign pipe_dxy      = dxy_q;
  assign pipe_valid    = vld_q;
  assign pipe_const_xx = kxx_o_q;
  assign pipe_const_xy = kxy_o_q;
  assign det_o         = det_q;
  assign det_o_valid   = det_vld_q;
  assign det_o_layer   = det_lay_q;
  assign frame_done    = done_q;
  assign err_tag       = err_q;
endmodule

// File: tb/tb_deth_layer_sched.sv
// Scoreboard bench for deth_layer_sched with a behavioural det pipeline
// (operands at stage 0, constants added at stage 2, LAT cycles from pipe_valid).
module tb_deth_layer_sched;
  localparam int N = 4, DW = 21, CW = 18, OW = 32, LAT = 4, CONST_DLY = 2, FP = 4;
  localparam int LW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         layer_en;
  logic                 cfg_we, cfg_sel;
  logic [LW-1:0]        cfg_layer;
  logic [CW-1:0]        cfg_wdata;
  logic signed [DW-1:0] pipe_dxx, pipe_dyy, pipe_dxy;
  logic                 pipe_valid;
  logic [CW-1:0]        pipe_const_xx, pipe_const_xy;
  logic signed [OW-1:0] pipe_det;
  logic                 pipe_det_valid;
  logic signed [OW-1:0] det_o;
  logic                 det_o_valid;
  logic [LW-1:0]        det_o_layer;
  logic [N-1:0]         frame_done;
  logic                 err_tag;

  deth_layer_sched_if #(.N(N), .DW(DW)) rif ();

  deth_layer_sched #(
    .N(N), .DW(DW), .CW(CW), .OW(OW), .LAT(LAT), .CONST_DLY(CONST_DLY), .FRAME_PIX(FP)
  ) dut (
    .clk(clk), .rst(rst), .layer_en(layer_en), .req_if(rif),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .pipe_dxx(pipe_dxx), .pipe_dyy(pipe_dyy), .pipe_dxy(pipe_dxy), .pipe_valid(pipe_valid),
    .pipe_const_xx(pipe_const_xx), .pipe_const_xy(pipe_const_xy),
    .pipe_det(pipe_det), .pipe_det_valid(pipe_det_valid),
    .det_o(det_o), .det_o_valid(det_o_valid), .det_o_layer(det_o_layer),
    .frame_done(frame_done), .err_tag(err_tag)
  );

  // Stimulus vectors and the det function of the behavioural pipeline
  function automatic int vxx(int l, int s); return l * 1000 + s; endfunction
  function automatic int vyy(int l, int s); return -(l * 37) - 3 * s; endfunction
  function automatic int vxy(int l, int s); return 2 * s - 11 * l; endfunction
  function automatic int opsum(int a, int b, int c); return 3 * a + 5 * b - 7 * c; endfunction
  function automatic int ksum(int xx, int xy); return xx + 2 * xy; endfunction

  // Behavioural det pipeline sharing rst with the scheduler
  logic pv [LAT];
  int   pa [LAT];
  logic inj = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= pipe_valid;
      pa[0] <= opsum(pipe_dxx, pipe_dyy, pipe_dxy);
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1] + ((k == 2 && pv[1]) ? ksum(int'(pipe_const_xx), int'(pipe_const_xy)) : 0);
      end
    end
  end

  assign pipe_det_valid = pv[LAT-1] | inj;
  assign pipe_det       = pa[LAT-1];

  typedef struct {
    int           det;
    int           layer;
    logic [N-1:0] done;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  int   rem [N], seq [N], kxx_m [N], kxy_m [N], fcnt_m [N], dgnt [N], res_cnt [N], done_cnt [N];
  int   ptr_m, ngr;
  int   first_det_cyc = -1;
  logic arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (det_o_valid === 1'b1) begin
          if (arm && first_det_cyc < 0) first_det_cyc = cyc;
          res_cnt[det_o_layer]++;
          for (int i = 0; i < N; i++) if (frame_done[i]) done_cnt[i]++;
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = sb.pop_front();
            chk("det_o", det_o, e.det);
            chk("det_o_layer", det_o_layer, e.layer);
            chk("frame_done", frame_done, e.done);
          end
        end else if (frame_done !== '0) begin
          chk("spurious_frame_done", frame_done, 0);
        end
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    ptr_m = 0;
    for (int i = 0; i < N; i++) begin
      kxx_m[i] = 1165;
      kxy_m[i] = 2595;
      fcnt_m[i] = 0;
    end
  endtask

  // One clock: drive requests, predict the grant, check ready, push the expected result
  task automatic tick();
    int           g;
    logic [N-1:0] expr;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      rif.req_valid[i]          = (rem[i] > 0);
      rif.req_dxx[i*DW +: DW]   = DW'(vxx(i, seq[i]));
      rif.req_dyy[i*DW +: DW]   = DW'(vyy(i, seq[i]));
      rif.req_dxy[i*DW +: DW]   = DW'(vxy(i, seq[i]));
    end
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (g < 0 && rif.req_valid[j] && layer_en[j]) g = j;
      end
    end
    expr = '0;
    if (g >= 0) expr[g] = 1'b1;
    #3;
    chk("req_ready", rif.req_ready, expr);
    for (int i = 0; i < N; i++) if (rif.req_ready[i]) dgnt[i]++;
    if (g >= 0) begin
      e.det   = opsum(vxx(g, seq[g]), vyy(g, seq[g]), vxy(g, seq[g])) + ksum(kxx_m[g], kxy_m[g]);
      e.layer = g;
      e.done  = '0;
      if (fcnt_m[g] == FP - 1) begin
        e.done[g] = 1'b1;
        fcnt_m[g] = 0;
      end else fcnt_m[g]++;
      sb.push_back(e);
      rem[g]--;
      seq[g]++;
      ptr_m = (g + 1) % N;
      ngr++;
    end
    if (cfg_we && !rst) begin
      if (cfg_sel) kxy_m[cfg_layer] = int'(cfg_wdata);
      else         kxx_m[cfg_layer] = int'(cfg_wdata);
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_rem();
    for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_empty();
    for (int k = 0; k < 300 && any_rem(); k++) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(int l, bit sel, int val);
    cfg_we = 1'b1; cfg_layer = LW'(l); cfg_sel = sel; cfg_wdata = CW'(val);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_pipe_valid"}, pipe_valid, 0);
    chk({tag, "_pipe_dxx"}, pipe_dxx, 0);
    chk({tag, "_pipe_dxy"}, pipe_dxy, 0);
    chk({tag, "_const_xx"}, pipe_const_xx, 1165);
    chk({tag, "_const_xy"}, pipe_const_xy, 2595);
    chk({tag, "_det_o"}, det_o, 0);
    chk({tag, "_det_o_valid"}, det_o_valid, 0);
    chk({tag, "_det_o_layer"}, det_o_layer, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_tag"}, err_tag, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc, r3_0, g3_0, d1_0;
    rst = 1'b1; layer_en = '1; cfg_we = 1'b0; cfg_layer = '0; cfg_sel = 1'b0; cfg_wdata = '0;
    rif.req_valid = '0; rif.req_dxx = '0; rif.req_dyy = '0; rif.req_dxy = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; dgnt[i] = 0; res_cnt[i] = 0; done_cnt[i] = 0;
    end
    ngr = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset: requests pending but no grant while rst is high
    for (int i = 0; i < N; i++) rem[i] = 1;
    tick();
    tick();
    chk_reset_outputs("reset");
    for (int i = 0; i < N; i++) rem[i] = 0;
    rst = 1'b0;

    // Single layer 2 streaming 8 samples
    rem[2] = 8;
    arm = 1'b1;
    hs_cyc = cyc;
    tick();
    chk("t1_pipe_valid", pipe_valid, 1);
    run_until_empty();
    drain();
    chk("t1_first_det_latency", first_det_cyc - hs_cyc, 6);
    chk("t1_grants_l2", dgnt[2], 8);
    arm = 1'b0;

    // All four layers with distinct constants, 100 grants
    do_reset();
    for (int i = 0; i < N; i++) begin
      cfg_write(i, 1'b0, 100 + 10 * i);
      cfg_write(i, 1'b1, 3000 + 7 * i);
    end
    for (int i = 0; i < N; i++) begin
      dgnt[i] = 0;
      rem[i] = 25;
    end
    run_until_empty();
    drain();
    for (int i = 0; i < N; i++) chk($sformatf("t2_grants_l%0d", i), dgnt[i], 25);

    // Layers 1 and 3; layer 3 disabled after the 4th grant
    ngr = 0;
    r3_0 = res_cnt[3];
    rem[1] = 20; rem[3] = 20;
    for (int k = 0; k < 20 && ngr < 4; k++) tick();
    chk("t3_grants_before_drop", ngr, 4);
    layer_en[3] = 1'b0;
    g3_0 = dgnt[3];
    repeat (6) tick();
    chk("t3_no_grant_after_drop", dgnt[3] - g3_0, 0);
    rem[1] = 0; rem[3] = 0;
    drain();
    chk("t3_l3_results", res_cnt[3] - r3_0, 2);
    layer_en = '1;

    // Constant write colliding with a layer-0 grant
    do_reset();
    rem[0] = 1;
    cfg_we = 1'b1; cfg_layer = '0; cfg_sel = 1'b1; cfg_wdata = CW'(1000);
    tick();
    cfg_we = 1'b0;
    chk("t4_pipe_valid", pipe_valid, 1);
    tick();
    tick();
    chk("t4_old_const_xy", pipe_const_xy, 2595);
    chk("t4_old_const_xx", pipe_const_xx, 1165);
    rem[0] = 1;
    tick();
    tick();
    tick();
    chk("t4_new_const_xy", pipe_const_xy, 1000);
    drain();

    // Frame counting on layer 1 (frame of 4)
    do_reset();
    d1_0 = done_cnt[1];
    rem[1] = 9;
    run_until_empty();
    drain();
    chk("t5_frames_after_9", done_cnt[1] - d1_0, 2);
    rem[1] = 3;
    run_until_empty();
    drain();
    chk("t5_frames_after_12", done_cnt[1] - d1_0, 3);

    // Result without a tag, then reset mid-stream
    chk("t6_err_before", err_tag, 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t6_drop_valid", det_o_valid, 0);
    chk("t6_err_set", err_tag, 1);
    repeat (3) tick();
    chk("t6_err_sticky", err_tag, 1);
    rem[0] = 20; rem[2] = 20;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    rem[0] = 4; rem[2] = 4;
    run_until_empty();
    drain();
    chk("t6_err_after_reset", err_tag, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
